// File: rtl/tray_pkg.sv
// Shared definitions for the three-piece tray.
//   tray_state_t      : tray controller states
//   SLOT_CNT          : number of tray slots
//   slot_idx_t        : slot index (0..2; the value 3 marks "past the last slot")
//   next_unused_slot  : cyclic search for the next free slot, also used by the
//                       display highlight logic
package tray_pkg;

    localparam int SLOT_CNT = 3;

    typedef logic [1:0] slot_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_LOAD,
        ST_CHECK,
        ST_SELECT,
        ST_PLACE_WAIT,
        ST_OVER
    } tray_state_t;

    // Returns the next unused slot after cur, wrapping 2 -> 0.
    // If no other slot is unused, cur is returned unchanged.
    function automatic slot_idx_t next_unused_slot(input slot_idx_t cur,
                                                   input logic [SLOT_CNT-1:0] used);
        slot_idx_t result;
        slot_idx_t cand;
        logic      hit;
        result = cur;
        cand   = cur;
        hit    = 1'b0;
        for (int k = 1; k < SLOT_CNT; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!hit && !used[cand]) begin
                result = cand;
                hit    = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tray_fit_scanner.sv
// Walks the tray slots 0..2 asking the board fit-checker whether each unused
// piece fits anywhere. Used slots cost one cycle each. A missing fit_ack is
// treated as "does not fit" after ACK_TIMEOUT cycles of fit_req.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                high while the controller sits in CHECK
//   clear                 restart request; drops any pending fit_req
//   slot_used, shapes     tray contents (shapes[i] = slot i)
//   fit_req/fit_shape     request to fit-checker, held until fit_ack
//   fit_ack/fit_ok        fit-checker response
//   done/found/found_slot scan result, valid in the cycle done is high
module tray_fit_scanner
    import tray_pkg::*;
#(
    parameter int SHAPE_W     = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              clear,
    input  logic [SLOT_CNT-1:0]               slot_used,
    input  logic [SLOT_CNT-1:0][SHAPE_W-1:0]  shapes,
    output logic                              fit_req,
    output logic [SHAPE_W-1:0]                fit_shape,
    input  logic                              fit_ack,
    input  logic                              fit_ok,
    output logic                              done,
    output logic                              found,
    output slot_idx_t                         found_slot
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    slot_idx_t       idx_reg, idx_next;
    logic            req_reg, req_next;
    logic [TW-1:0]   timer_reg, timer_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg   <= '0;
            req_reg   <= 1'b0;
            timer_reg <= '0;
        end else begin
            idx_reg   <= idx_next;
            req_reg   <= req_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        idx_next   = idx_reg;
        req_next   = req_reg;
        timer_next = timer_reg;
        done       = 1'b0;
        found      = 1'b0;
        if (!enable || clear) begin
            idx_next   = '0;
            req_next   = 1'b0;
            timer_next = '0;
        end else if (idx_reg == 2'd3) begin
            // All slots tried without a fit.
            done = 1'b1;
        end else if (slot_used[idx_reg]) begin
            idx_next = idx_reg + 2'd1;
        end else if (!req_reg) begin
            req_next   = 1'b1;
            timer_next = '0;
        end else if (fit_ack) begin
            req_next   = 1'b0;
            timer_next = '0;
            if (fit_ok) begin
                done  = 1'b1;
                found = 1'b1;
            end else begin
                idx_next = idx_reg + 2'd1;
            end
        end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
            // fit_req has now been high for ACK_TIMEOUT cycles: give up.
            req_next   = 1'b0;
            timer_next = '0;
            idx_next   = idx_reg + 2'd1;
        end else begin
            timer_next = timer_reg + TW'(1);
        end
    end

    always_comb begin
        case (idx_reg)
            2'd0:    fit_shape = shapes[0];
            2'd1:    fit_shape = shapes[1];
            2'd2:    fit_shape = shapes[2];
            default: fit_shape = '0;
        endcase
    end

    assign fit_req    = req_reg;
    assign found_slot = idx_reg;

endmodule

// File: rtl/tray_sequencer.sv
// Tray controller: requests three shapes from the block generator, lets the
// player cycle/place them, and checks after every capture or placement
// whether any remaining piece still fits; otherwise declares game over.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start                         begin/restart a game (any state)
//   gen_new, block1..3            generator handshake and shapes
//   sel_next, place_req           player controls
//   place_valid, place_done,
//   place_accepted                board placement handshake
//   fit_req, fit_shape,
//   fit_ack, fit_ok               fit-checker handshake
//   active_slot, active_shape,
//   slot_used, tray_ready,
//   game_over                     tray status
// Optional: define PIECE_COUNT_EN to add pieces_placed[15:0], a saturating
// count of accepted placements cleared by reset and start.
module tray_sequencer
    import tray_pkg::*;
#(
    parameter int SHAPE_W     = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                gen_new,
    input  logic [SHAPE_W-1:0]  block1,
    input  logic [SHAPE_W-1:0]  block2,
    input  logic [SHAPE_W-1:0]  block3,
    input  logic                sel_next,
    input  logic                place_req,
    output logic                place_valid,
    input  logic                place_done,
    input  logic                place_accepted,
    output logic                fit_req,
    output logic [SHAPE_W-1:0]  fit_shape,
    input  logic                fit_ack,
    input  logic                fit_ok,
    output logic [1:0]          active_slot,
    output logic [SHAPE_W-1:0]  active_shape,
    output logic [2:0]          slot_used,
    output logic                tray_ready,
    output logic                game_over
`ifdef PIECE_COUNT_EN
    ,
    output logic [15:0]         pieces_placed
`endif
);

    tray_state_t                       state_reg, state_next;
    logic [SLOT_CNT-1:0][SHAPE_W-1:0]  shape_reg;
    logic [SLOT_CNT-1:0]               slot_used_reg, slot_used_next;
    slot_idx_t                         active_slot_reg, active_slot_next;
    logic                              load_en;

    logic [SLOT_CNT-1:0][SHAPE_W-1:0]  block_in;
    logic [SLOT_CNT-1:0]               load_empty;
    logic [SLOT_CNT-1:0]               placed_mask;
    logic                              place_ok;

    logic                              scan_done, scan_found;
    slot_idx_t                         scan_slot;

    assign block_in = {block3, block2, block1};

    // A zero shape (e.g. from a generator still in reset) counts as empty.
    generate
        for (genvar gi = 0; gi < SLOT_CNT; gi++) begin : g_slot
            assign load_empty[gi] = (block_in[gi] == '0);
        end
    endgenerate

    assign placed_mask = slot_used_reg | (3'b001 << active_slot_reg);
    assign place_ok    = (state_reg == ST_PLACE_WAIT) && place_done && place_accepted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            shape_reg       <= '0;
            slot_used_reg   <= '1;
            active_slot_reg <= '0;
        end else begin
            state_reg       <= state_next;
            slot_used_reg   <= slot_used_next;
            active_slot_reg <= active_slot_next;
            if (load_en) begin
                shape_reg <= block_in;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        slot_used_next   = slot_used_reg;
        active_slot_next = active_slot_reg;
        load_en          = 1'b0;
        gen_new          = 1'b0;
        tray_ready       = 1'b0;
        place_valid      = 1'b0;
        game_over        = 1'b0;
        case (state_reg)
            ST_IDLE: ;
            ST_GEN: begin
                gen_new    = 1'b1;
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                load_en        = 1'b1;
                slot_used_next = load_empty;
                state_next     = (&load_empty) ? ST_GEN : ST_CHECK;
            end
            ST_CHECK: begin
                if (scan_done) begin
                    if (scan_found) begin
                        active_slot_next = scan_slot;
                        state_next       = ST_SELECT;
                    end else begin
                        state_next = ST_OVER;
                    end
                end
            end
            ST_SELECT: begin
                tray_ready = 1'b1;
                if (place_req) begin
                    state_next = ST_PLACE_WAIT;
                end else if (sel_next) begin
                    active_slot_next = next_unused_slot(active_slot_reg, slot_used_reg);
                end
            end
            ST_PLACE_WAIT: begin
                place_valid = 1'b1;
                if (place_done) begin
                    if (place_accepted) begin
                        slot_used_next = placed_mask;
                        state_next     = (&placed_mask) ? ST_GEN : ST_CHECK;
                    end else begin
                        state_next = ST_SELECT;
                    end
                end
            end
            ST_OVER: begin
                game_over = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        if (start) begin
            state_next = ST_GEN;
        end
    end

    tray_fit_scanner #(
        .SHAPE_W     (SHAPE_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_scanner (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (state_reg == ST_CHECK),
        .clear      (start),
        .slot_used  (slot_used_reg),
        .shapes     (shape_reg),
        .fit_req    (fit_req),
        .fit_shape  (fit_shape),
        .fit_ack    (fit_ack),
        .fit_ok     (fit_ok),
        .done       (scan_done),
        .found      (scan_found),
        .found_slot (scan_slot)
    );

    assign active_slot  = active_slot_reg;
    assign slot_used    = slot_used_reg;
    assign active_shape = slot_used_reg[active_slot_reg] ? '0 : shape_reg[active_slot_reg];

`ifdef PIECE_COUNT_EN
    logic [15:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= '0;
        end else if (place_ok && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign pieces_placed = count_reg;
`else
    logic unused_place_ok;
    assign unused_place_ok = place_ok;
`endif

endmodule

// File: tb/tb_tray_sequencer.sv
module tb_tray_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        gen_new;
    logic [63:0] block1, block2, block3;
    logic        sel_next, place_req, place_valid, place_done, place_accepted;
    logic        fit_req;
    logic [63:0] fit_shape;
    logic        fit_ack, fit_ok;
    logic [1:0]  active_slot;
    logic [63:0] active_shape;
    logic [2:0]  slot_used;
    logic        tray_ready, game_over;
`ifdef PIECE_COUNT_EN
    logic [15:0] pieces_placed;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int gen_cnt = 0;

    tray_sequencer #(.SHAPE_W(64), .ACK_TIMEOUT(255)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .gen_new        (gen_new),
        .block1         (block1),
        .block2         (block2),
        .block3         (block3),
        .sel_next       (sel_next),
        .place_req      (place_req),
        .place_valid    (place_valid),
        .place_done     (place_done),
        .place_accepted (place_accepted),
        .fit_req        (fit_req),
        .fit_shape      (fit_shape),
        .fit_ack        (fit_ack),
        .fit_ok         (fit_ok),
        .active_slot    (active_slot),
        .active_shape   (active_shape),
        .slot_used      (slot_used),
        .tray_ready     (tray_ready),
        .game_over      (game_over)
`ifdef PIECE_COUNT_EN
        ,
        .pieces_placed  (pieces_placed)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gen_new === 1'b1) gen_cnt <= gen_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_game(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        block1 = a; block2 = b; block3 = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("txn start blocks=%0h/%0h/%0h", a, b, c);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (fit_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack(input logic ok);
        fit_ack = 1'b1; fit_ok = ok;
        @(negedge clk);
        fit_ack = 1'b0; fit_ok = 1'b0;
        $display("txn fit_ack fit_ok=%0b", ok);
    endtask

    task automatic do_place(input logic acc);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        place_done = 1'b1; place_accepted = acc;
        @(negedge clk);
        place_done = 1'b0; place_accepted = 1'b0;
        $display("txn place accepted=%0b slot_used=%b", acc, slot_used);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (gen_new !== 1'b0) begin n_bad++; $display("FAIL rst_gen_new got=%b want=0", gen_new); end
        n_cmp++; if (fit_req !== 1'b0) begin n_bad++; $display("FAIL rst_fit_req got=%b want=0", fit_req); end
        n_cmp++; if (place_valid !== 1'b0) begin n_bad++; $display("FAIL rst_place_valid got=%b want=0", place_valid); end
        n_cmp++; if (tray_ready !== 1'b0) begin n_bad++; $display("FAIL rst_tray_ready got=%b want=0", tray_ready); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL rst_game_over got=%b want=0", game_over); end
        n_cmp++; if (slot_used !== 3'b111) begin n_bad++; $display("FAIL rst_slot_used got=%b want=111", slot_used); end
        n_cmp++; if (active_slot !== 2'd0) begin n_bad++; $display("FAIL rst_active_slot got=%0d want=0", active_slot); end
        n_cmp++; if (active_shape !== 64'h0) begin n_bad++; $display("FAIL rst_active_shape got=%0h want=0", active_shape); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (gen_new !== 1'b0) begin n_bad++; $display("FAIL idle_gen_new got=%b want=0", gen_new); end
        $display("txn reset done");
    endtask

    task automatic test_first_load;
        int g0;
        bit ok;
        g0 = gen_cnt;
        start_game(64'h301, 64'h303, 64'h7);
        n_cmp++; if (gen_new !== 1'b1) begin n_bad++; $display("FAIL gen_pulse got=%b want=1", gen_new); end
        @(negedge clk);
        n_cmp++; if (gen_new !== 1'b0) begin n_bad++; $display("FAIL gen_one_cycle got=%b want=0", gen_new); end
        @(negedge clk);
        n_cmp++; if (slot_used !== 3'b000) begin n_bad++; $display("FAIL load_used got=%b want=000", slot_used); end
        wait_req(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL first_req_timeout got=%b want=1", ok); end
        n_cmp++; if (fit_shape !== 64'h301) begin n_bad++; $display("FAIL first_fit_shape got=%0h want=301", fit_shape); end
        ack(1'b1);
        n_cmp++; if (tray_ready !== 1'b1) begin n_bad++; $display("FAIL first_select got=%b want=1", tray_ready); end
        n_cmp++; if (active_slot !== 2'd0) begin n_bad++; $display("FAIL first_active got=%0d want=0", active_slot); end
        n_cmp++; if (fit_req !== 1'b0) begin n_bad++; $display("FAIL first_req_drop got=%b want=0", fit_req); end
        n_cmp++; if (active_shape !== 64'h301) begin n_bad++; $display("FAIL first_active_shape got=%0h want=301", active_shape); end
        n_cmp++; if (gen_cnt - g0 !== 1) begin n_bad++; $display("FAIL first_gen_count got=%0d want=1", gen_cnt - g0); end
    endtask

    task automatic test_sel_cycle;
        bit ok;
        logic [1:0] exp_seq [3] = '{2'd2, 2'd0, 2'd2};
        start_game(64'h301, 64'h0, 64'h7);
        repeat (2) @(negedge clk);
        n_cmp++; if (slot_used !== 3'b010) begin n_bad++; $display("FAIL sel_used got=%b want=010", slot_used); end
        wait_req(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sel_req_timeout got=%b want=1", ok); end
        ack(1'b1);
        for (int i = 0; i < 3; i++) begin
            sel_next = 1'b1;
            @(negedge clk);
            sel_next = 1'b0;
            $display("txn sel_next active_slot=%0d", active_slot);
            n_cmp++; if (active_slot !== exp_seq[i]) begin n_bad++; $display("FAIL sel_step%0d got=%0d want=%0d", i, active_slot, exp_seq[i]); end
        end
        n_cmp++; if (active_shape !== 64'h7) begin n_bad++; $display("FAIL sel_shape got=%0h want=7", active_shape); end
        // place_req beats a simultaneous sel_next
        place_req = 1'b1; sel_next = 1'b1;
        @(negedge clk);
        place_req = 1'b0; sel_next = 1'b0;
        n_cmp++; if (place_valid !== 1'b1) begin n_bad++; $display("FAIL prio_place_valid got=%b want=1", place_valid); end
        n_cmp++; if (active_slot !== 2'd2) begin n_bad++; $display("FAIL prio_active got=%0d want=2", active_slot); end
        sel_next = 1'b1;
        @(negedge clk);
        sel_next = 1'b0;
        n_cmp++; if (active_slot !== 2'd2) begin n_bad++; $display("FAIL wait_sel_ignored got=%0d want=2", active_slot); end
        place_done = 1'b1; place_accepted = 1'b0;
        @(negedge clk);
        place_done = 1'b0;
        $display("txn place rejected");
        n_cmp++; if (tray_ready !== 1'b1) begin n_bad++; $display("FAIL reject_select got=%b want=1", tray_ready); end
        n_cmp++; if (slot_used !== 3'b010) begin n_bad++; $display("FAIL reject_used got=%b want=010", slot_used); end
    endtask

    task automatic test_three_places;
        bit ok;
        int g0;
        start_game(64'h301, 64'h303, 64'h7);
        repeat (2) @(negedge clk);
        wait_req(ok);
        ack(1'b1);
        do_place(1'b1);
        n_cmp++; if (slot_used !== 3'b001) begin n_bad++; $display("FAIL p1_used got=%b want=001", slot_used); end
        wait_req(ok);
        n_cmp++; if (fit_shape !== 64'h303) begin n_bad++; $display("FAIL p1_fit_shape got=%0h want=303", fit_shape); end
        ack(1'b1);
        n_cmp++; if (active_slot !== 2'd1) begin n_bad++; $display("FAIL p1_active got=%0d want=1", active_slot); end
        do_place(1'b1);
        n_cmp++; if (slot_used !== 3'b011) begin n_bad++; $display("FAIL p2_used got=%b want=011", slot_used); end
        wait_req(ok);
        n_cmp++; if (fit_shape !== 64'h7) begin n_bad++; $display("FAIL p2_fit_shape got=%0h want=7", fit_shape); end
        ack(1'b1);
        n_cmp++; if (active_slot !== 2'd2) begin n_bad++; $display("FAIL p2_active got=%0d want=2", active_slot); end
        block1 = 64'h1; block2 = 64'h2; block3 = 64'h4;
        g0 = gen_cnt;
        do_place(1'b1);
        n_cmp++; if (slot_used !== 3'b111) begin n_bad++; $display("FAIL p3_used got=%b want=111", slot_used); end
        n_cmp++; if (gen_new !== 1'b1) begin n_bad++; $display("FAIL p3_gen got=%b want=1", gen_new); end
        repeat (2) @(negedge clk);
        n_cmp++; if (slot_used !== 3'b000) begin n_bad++; $display("FAIL reload_used got=%b want=000", slot_used); end
        n_cmp++; if (active_shape !== 64'h4) begin n_bad++; $display("FAIL reload_shape got=%0h want=4", active_shape); end
        repeat (3) @(negedge clk);
        n_cmp++; if (gen_cnt - g0 !== 1) begin n_bad++; $display("FAIL refill_gen_count got=%0d want=1", gen_cnt - g0); end
    endtask

    task automatic test_game_over;
        bit ok;
        start_game(64'h301, 64'h303, 64'h7);
        repeat (2) @(negedge clk);
        wait_req(ok);
        ack(1'b1);
        do_place(1'b1);
        wait_req(ok);
        n_cmp++; if (fit_shape !== 64'h303) begin n_bad++; $display("FAIL go_shape1 got=%0h want=303", fit_shape); end
        ack(1'b0);
        wait_req(ok);
        n_cmp++; if (fit_shape !== 64'h7) begin n_bad++; $display("FAIL go_shape2 got=%0h want=7", fit_shape); end
        ack(1'b0);
        for (int i = 0; i < 10 && game_over !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL go_set got=%b want=1", game_over); end
        n_cmp++; if (tray_ready !== 1'b0) begin n_bad++; $display("FAIL go_ready got=%b want=0", tray_ready); end
        repeat (5) @(negedge clk);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL go_sticky got=%b want=1", game_over); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("txn restart from OVER");
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL go_clear got=%b want=0", game_over); end
        n_cmp++; if (gen_new !== 1'b1) begin n_bad++; $display("FAIL go_restart_gen got=%b want=1", gen_new); end
    endtask

    task automatic test_timeout;
        bit ok;
        int n;
        repeat (2) @(negedge clk);
        wait_req(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL to_req got=%b want=1", ok); end
        n = 0;
        while (fit_req === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        $display("txn fit_req held %0d cycles", n);
        n_cmp++; if (n !== 255) begin n_bad++; $display("FAIL to_hold got=%0d want=255", n); end
        wait_req(ok);
        n_cmp++; if (fit_shape !== 64'h303) begin n_bad++; $display("FAIL to_next_shape got=%0h want=303", fit_shape); end
        for (int i = 0; i < 1000 && game_over !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL to_over got=%b want=1", game_over); end
    endtask

    task automatic test_restart_mid_check;
        bit ok;
        start_game(64'h301, 64'h303, 64'h7);
        repeat (2) @(negedge clk);
        wait_req(ok);
        n_cmp++; if (fit_req !== 1'b1) begin n_bad++; $display("FAIL mid_req got=%b want=1", fit_req); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("txn restart during CHECK");
        n_cmp++; if (fit_req !== 1'b0) begin n_bad++; $display("FAIL mid_req_clear got=%b want=0", fit_req); end
        n_cmp++; if (gen_new !== 1'b1) begin n_bad++; $display("FAIL mid_gen got=%b want=1", gen_new); end
    endtask

    task automatic test_reset_in_place_wait;
        bit ok;
        repeat (2) @(negedge clk);
        wait_req(ok);
        ack(1'b1);
        place_req = 1'b1;
        @(negedge clk);
        place_req = 1'b0;
        n_cmp++; if (place_valid !== 1'b1) begin n_bad++; $display("FAIL rpw_valid got=%b want=1", place_valid); end
        #2 reset_n = 1'b0;
        #1;
        $display("txn async reset in PLACE_WAIT");
        n_cmp++; if (place_valid !== 1'b0) begin n_bad++; $display("FAIL rpw_valid_rst got=%b want=0", place_valid); end
        n_cmp++; if (slot_used !== 3'b111) begin n_bad++; $display("FAIL rpw_used_rst got=%b want=111", slot_used); end
        n_cmp++; if (active_shape !== 64'h0) begin n_bad++; $display("FAIL rpw_shape_rst got=%0h want=0", active_shape); end
        @(negedge clk);
        reset_n = 1'b1;
        place_done = 1'b1; place_accepted = 1'b1;
        @(negedge clk);
        place_done = 1'b0; place_accepted = 1'b0;
        @(negedge clk);
        n_cmp++; if (slot_used !== 3'b111) begin n_bad++; $display("FAIL rpw_ignored got=%b want=111", slot_used); end
        n_cmp++; if (gen_new !== 1'b0 || place_valid !== 1'b0) begin n_bad++; $display("FAIL rpw_idle got=%b%b want=00", gen_new, place_valid); end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0;
        block1 = '0; block2 = '0; block3 = '0;
        sel_next = 1'b0; place_req = 1'b0; place_done = 1'b0; place_accepted = 1'b0;
        fit_ack = 1'b0; fit_ok = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_load();
        test_sel_cycle();
        test_three_places();
        test_game_over();
        test_timeout();
        test_restart_mid_check();
        test_reset_in_place_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tray_sequencer.md
Name: tray_sequencer

Overview:
Controls the three-piece tray that feeds the 8x8 board.
- Pulses the block generator for a fresh set of three 64-bit shapes and captures them.
- Lets the player cycle through and place unused pieces.
- After every capture or placement, asks the board fit-checker whether any remaining piece fits anywhere; declares game over when none does.
- Sits between block_generator, the input debouncers and the board/placement logic.

Parameters:
SHAPE_W, 64, width of one shape bitmap (8x8 grid, bit 0 = top-left).
ACK_TIMEOUT, 255, cycles to wait for fit_ack before treating the piece as "does not fit".

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin or restart a game
gen_new  out  1  one-cycle pulse to block_generator.generate_new
block1  in  SHAPE_W  generator slot 0 shape
block2  in  SHAPE_W  generator slot 1 shape
block3  in  SHAPE_W  generator slot 2 shape
sel_next  in  1  pulse; advance the active slot
place_req  in  1  pulse; player confirms placement of the active piece
place_valid  out  1  high while awaiting the board's placement result
place_done  in  1  one-cycle pulse; board finished the placement attempt
place_accepted  in  1  qualifies place_done; 1 = piece written to the board
fit_req  out  1  fit-check request, held until fit_ack
fit_shape  out  SHAPE_W  shape under test; stable while fit_req is high
fit_ack  in  1  one-cycle pulse; fit_ok is valid
fit_ok  in  1  1 = shape fits somewhere on the board
active_slot  out  2  selected slot, 0..2
active_shape  out  SHAPE_W  shape in active_slot, or 0 when that slot is used
slot_used  out  3  per-slot used/empty flags
tray_ready  out  1  high in SELECT only
game_over  out  1  sticky until start or reset

Behaviour:
- States: IDLE, GEN, LOAD, CHECK, SELECT, PLACE_WAIT, OVER.
- Reset values (reset_n low, asynchronous):
  - state = IDLE; gen_new, fit_req, place_valid, tray_ready and game_over = 0.
  - Shape registers = 0; slot_used = 3'b111; active_slot = 0; scan index = 0; timeout counter = 0.
- start:
  - Honoured in every state, including mid-operation.
  - Next state GEN; game_over and fit_req cleared.
- IDLE: waits for start.
- GEN:
  - gen_new = 1 for exactly one cycle, then LOAD.
  - The generator updates its outputs on that same edge.
- LOAD:
  - Captures block1..3 into slots 0..2.
  - slot_used[i] = (shape_i == 0), so a zero shape from a reset generator counts as empty.
  - If all three are zero, go to GEN again; otherwise go to CHECK with scan index 0.
- CHECK scans slots 0, 1, 2 in order:
  - A used slot costs one cycle and is skipped.
  - For an unused slot: fit_req = 1 and fit_shape = slot shape, held until fit_ack. fit_req drops the cycle after fit_ack.
  - fit_ok = 1: active_slot = that slot, go to SELECT.
  - fit_ok = 0: next slot.
  - Timeout counter reaches ACK_TIMEOUT without fit_ack: treated as fit_ok = 0.
  - Scan completes with no fit: go to OVER.
- SELECT:
  - tray_ready = 1.
  - sel_next moves active_slot to the next unused slot cyclically (2 wraps to 0). With exactly one unused slot, active_slot is unchanged.
  - place_req goes to PLACE_WAIT. place_req has priority if sel_next arrives in the same cycle, and sel_next is then ignored.
- PLACE_WAIT:
  - place_valid = 1; sel_next and place_req are ignored.
  - On place_done with place_accepted = 1: set slot_used[active_slot]. If all three are used, go to GEN; otherwise go to CHECK.
  - On place_done with place_accepted = 0: back to SELECT, tray state unchanged.
- OVER: game_over = 1; leaves only on start.
- active_shape is combinational from the shape registers, masked to 0 when the slot is used.

Optional Feature:
PIECE_COUNT_EN.
- Defined: adds output pieces_placed[15:0].
  - Increments on each accepted placement; saturates at 16'hFFFF.
  - Cleared by reset and by start.
- Undefined: port and counter absent; no other behavioural change.

Decomposition:
- Shared package tray_pkg holds:
  - the state enum;
  - SLOT_CNT = 3;
  - the slot index type;
  - the "next unused slot" function (also used by the VGA highlight logic).
- One natural sub-module, tray_fit_scanner: the CHECK scan and timeout, with start/done/found/slot handshake to the main FSM.

Test Plan:
- Start, then generator returns 0x301/0x303/0x7; fit_ok = 1 on the first ack -> one gen_new pulse, slot_used = 000, fit_shape = 0x301, SELECT with active_slot = 0.
- In SELECT, sel_next x3 with slot 1 used -> active_slot sequence 0 -> 2 -> 0 -> 2.
- Three accepted placements -> slot_used reaches 111, exactly one new gen_new pulse, then LOAD.
- After a placement, fit_ok = 0 for both remaining slots -> game_over = 1; a later start clears it and pulses gen_new.
- fit_ack never arrives -> fit_req held for ACK_TIMEOUT cycles, then the next slot is tested; all time out -> OVER.
- reset_n low during PLACE_WAIT -> outputs at reset values immediately; place_accepted pulse after release is ignored.
